// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and instruction-type codes for the sequencer and control unit
package seq_pkg;
    localparam int PC_W_DEF = 10;
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM_WAIT, DONE} state_t;
    typedef enum logic [1:0] {ITYPE_R = 2'b00, ITYPE_M = 2'b01, ITYPE_B = 2'b10, ITYPE_S = 2'b11} itype_t;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: loadable down-counter that flags an expired memory wait
module seq_watchdog #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);
    logic [7:0] cnt;
    assign expire = run && cnt == 8'd0;
    // load leaves TMO-1 so the TMO-th waiting cycle is the one that expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= 8'(TMO - 1);
        else if (run && cnt != 8'd0) cnt <= cnt - 8'd1;
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer owning the PC, commit gating and run control
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int PROG_LEN = 1024,
    parameter int MEM_TMO  = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt,
    input  logic             branch_en,
    input  logic [PC_W-1:0]  branch_tgt,
    input  logic             mem_op,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             exec_valid,
    output logic             mem_en,
    output logic             commit,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_cnt
);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
    state_t state, state_n;
    logic [PC_W-1:0] pc_n;
    logic error_n, start_q, launch, last, wd_expire;
    assign launch     = start && !start_q && (state == IDLE || state == DONE);
    assign last       = pc == LAST_PC;
    assign exec_valid = state == EXEC;
    assign busy       = state inside {FETCH, EXEC, MEM_WAIT};
    assign done       = state == DONE;
    assign mem_en     = exec_valid && !halt && mem_op;
    assign commit     = (exec_valid && !halt && !mem_op) || (state == MEM_WAIT && mem_ready);
    seq_watchdog #(.TMO(MEM_TMO)) u_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mem_en),
        .run    (state == MEM_WAIT),
        .expire (wd_expire)
    );
    // next state, next PC and sticky error
    always_comb begin
        state_n = state;
        pc_n    = pc;
        error_n = error;
        case (state)
            IDLE, DONE: begin
                if (launch) begin
                    state_n = FETCH;
                    pc_n    = '0;
                    error_n = 1'b0;
                end
            end
            FETCH: state_n = EXEC;
            EXEC: begin
                if (halt) state_n = DONE;
                else if (mem_op) state_n = MEM_WAIT;
                else if (branch_en) begin
                    state_n = FETCH;
                    pc_n    = branch_tgt;
                end else begin
                    state_n = last ? DONE : FETCH;
                    pc_n    = last ? pc : pc + PC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_n = last ? DONE : FETCH;
                    pc_n    = last ? pc : pc + PC_W'(1);
                end else if (wd_expire) begin
                    state_n = DONE;
                    error_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state, PC, error and start history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            error   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            error   <= error_n;
            start_q <= start;
        end
    end
    // saturating busy-cycle counter, cleared on launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= '0;
        else if (launch) cycle_cnt <= '0;
        else if (busy && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench driving instruction streams against a step-level reference model
module tb_instr_sequencer;
    localparam int PC_W = 10, PROG_LEN = 1024, MEM_TMO = 15, CNT_W = 32;
    localparam int K_ALU = 0, K_BR = 1, K_MEM = 2, K_HALT = 3, K_TMO = 4;
    typedef struct packed {
        logic [2:0] kind;
        logic [9:0] tgt;
        logic [3:0] lat;
        logic       rdy_exec;
    } step_t;
    logic clk = 0, rst_n = 0, start = 0, halt = 0, branch_en = 0, mem_op = 0, mem_ready = 0;
    logic [PC_W-1:0] branch_tgt = '0;
    logic [PC_W-1:0] pc;
    logic exec_valid, mem_en, commit, busy, done, error;
    logic [CNT_W-1:0] cycle_cnt;
    int tests = 0, fails = 0;
    bit mon_en = 0;
    step_t steps[$];
    int exp_exec[$], exp_mem[$], exp_commit[$];
    int n_run, exp_pc, exp_cnt;
    bit exp_err;

    instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN), .MEM_TMO(MEM_TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .branch_en(branch_en),
        .branch_tgt(branch_tgt), .mem_op(mem_op), .mem_ready(mem_ready), .pc(pc),
        .exec_valid(exec_valid), .mem_en(mem_en), .commit(commit), .busy(busy), .done(done),
        .error(error), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // scoreboard monitor: every exec/mem_en/commit event must match the next expected PC
    always @(negedge clk) begin
        if (mon_en) begin
            if (exec_valid) begin
                check("exec_expected", exp_exec.size() > 0, 1);
                if (exp_exec.size() > 0) check("exec_pc", pc, exp_exec.pop_front());
            end
            if (mem_en) begin
                check("mem_en_expected", exp_mem.size() > 0, 1);
                if (exp_mem.size() > 0) check("mem_en_pc", pc, exp_mem.pop_front());
            end
            if (commit) begin
                check("commit_expected", exp_commit.size() > 0, 1);
                if (exp_commit.size() > 0) check("commit_pc", pc, exp_commit.pop_front());
            end
        end
    end

    task automatic add(input int k, input int t, input int l, input bit r);
        step_t s;
        s.kind = 3'(k);
        s.tgt = 10'(t);
        s.lat = 4'(l);
        s.rdy_exec = r;
        steps.push_back(s);
    endtask

    // reference: walk the instruction stream with plain PC arithmetic
    task automatic model();
        int p = 0;
        exp_cnt = 0;
        exp_err = 0;
        exp_exec.delete();
        exp_mem.delete();
        exp_commit.delete();
        n_run = steps.size();
        for (int i = 0; i < steps.size(); i++) begin
            bit term;
            int k;
            term = 0;
            k = int'(steps[i].kind);
            exp_exec.push_back(p);
            exp_cnt += 2;
            if (k == K_HALT) term = 1;
            else if (k == K_TMO) begin
                exp_mem.push_back(p);
                exp_cnt += MEM_TMO;
                exp_err = 1;
                term = 1;
            end else if (k == K_BR) begin
                exp_commit.push_back(p);
                p = int'(steps[i].tgt);
            end else begin
                if (k == K_MEM) begin
                    exp_mem.push_back(p);
                    exp_cnt += int'(steps[i].lat);
                end
                exp_commit.push_back(p);
                if (p == PROG_LEN - 1) term = 1;
                else p++;
            end
            if (term) begin
                n_run = i + 1;
                break;
            end
        end
        exp_pc = p;
    endtask

    task automatic launch(input bit hold);
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        check("launch_pc", pc, 0);
        check("launch_cnt", cycle_cnt, 0);
        check("launch_busy", busy, 1);
        check("launch_error", error, 0);
        if (!hold) start = 0;
    endtask

    task automatic wait_exec();
        int b = 0;
        while (!exec_valid && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        check("exec_reached", exec_valid, 1);
    endtask

    task automatic run_prog(input bit hold);
        int b = 0;
        model();
        mon_en = 1;
        launch(hold);
        for (int i = 0; i < n_run; i++) begin
            step_t s;
            int k;
            s = steps[i];
            k = int'(s.kind);
            wait_exec();
            if (!exec_valid) break;
            halt = k == K_HALT;
            mem_op = k == K_MEM || k == K_TMO;
            branch_en = k == K_BR ? 1'b1 : k == K_ALU ? 1'b0 : 1'($urandom_range(0, 1));
            branch_tgt = k == K_BR ? s.tgt : PC_W'($urandom);
            mem_ready = mem_op && s.rdy_exec;
            @(posedge clk); #1;
            {halt, mem_op, branch_en, mem_ready} = '0;
            if (k == K_MEM) begin
                repeat (int'(s.lat) - 1) begin
                    @(posedge clk); #1;
                end
                mem_ready = 1;
                @(posedge clk); #1;
                mem_ready = 0;
            end
        end
        while (!done && b < 40) begin
            @(posedge clk); #1;
            b++;
        end
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("final_pc", pc, exp_pc);
        check("final_error", error, exp_err);
        check("final_cycle_cnt", cycle_cnt, exp_cnt);
        check("exec_left", exp_exec.size(), 0);
        check("mem_en_left", exp_mem.size(), 0);
        check("commit_left", exp_commit.size(), 0);
        mon_en = 0;
    endtask

    task automatic gen_random();
        int n = $urandom_range(3, 12);
        steps.delete();
        for (int i = 0; i < n - 1; i++) begin
            int r = $urandom_range(0, 19);
            int t = $urandom_range(0, 3) == 0 ? $urandom_range(PROG_LEN - 5, PROG_LEN - 1) : $urandom_range(0, PROG_LEN - 1);
            add(r < 9 ? K_ALU : r < 13 ? K_BR : r < 19 ? K_MEM : K_TMO, t, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end
        add(K_HALT, 0, 1, 0);
    endtask

    initial begin
        #12;
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_strobes", {exec_valid, mem_en, commit}, 0);
        @(negedge clk) rst_n = 1;
        // three ALU ops then halt
        steps.delete();
        repeat (3) add(K_ALU, 0, 1, 0);
        add(K_HALT, 0, 1, 0);
        run_prog(0);
        // taken branch at pc 2 to 0x1F0
        steps.delete();
        add(K_ALU, 0, 1, 0); add(K_ALU, 0, 1, 0); add(K_BR, 'h1F0, 1, 0); add(K_ALU, 0, 1, 0); add(K_HALT, 0, 1, 0);
        run_prog(0);
        // not-taken at pc 2 continues to pc 3
        steps.delete();
        repeat (3) add(K_ALU, 0, 1, 0);
        add(K_HALT, 0, 1, 0);
        run_prog(0);
        // load answered on the 4th wait cycle, with an ignored ready during EXEC
        steps.delete();
        add(K_ALU, 0, 1, 0); add(K_MEM, 0, 4, 1); add(K_ALU, 0, 1, 0); add(K_HALT, 0, 1, 0);
        run_prog(0);
        // memory never answers
        steps.delete();
        add(K_ALU, 0, 1, 0); add(K_TMO, 0, 1, 0);
        run_prog(0);
        #2 rst_n = 0;
        #1 check("rst_clears_error", error, 0);
        check("rst_clears_done", done, 0);
        @(negedge clk) rst_n = 1;
        // last instruction with start held high throughout
        steps.delete();
        add(K_BR, PROG_LEN - 2, 1, 0); add(K_ALU, 0, 1, 0); add(K_ALU, 0, 1, 0); add(K_HALT, 0, 1, 0);
        run_prog(1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("held_start_done", done, 1);
        check("held_start_pc", pc, PROG_LEN - 1);
        start = 0;
        // memory op at the last address
        steps.delete();
        add(K_BR, PROG_LEN - 1, 1, 0); add(K_MEM, 0, 2, 0); add(K_HALT, 0, 1, 0);
        run_prog(0);
        // async reset mid MEM_WAIT
        launch(0);
        wait_exec();
        branch_en = 1;
        branch_tgt = 5;
        @(posedge clk); #1;
        branch_en = 0;
        wait_exec();
        check("t1_exec_pc", pc, 5);
        mem_op = 1;
        @(posedge clk); #1;
        mem_op = 0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("t1_waiting", {busy, exec_valid}, 2'b10);
        #2 rst_n = 0;
        #1 check("t1_pc", pc, 0);
        check("t1_busy", busy, 0);
        check("t1_error", error, 0);
        check("t1_cnt", cycle_cnt, 0);
        @(negedge clk) rst_n = 1;
        for (int r = 0; r < 30; r++) begin
            gen_random();
            run_prog(0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
